// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch port and the load/store port.
// One transaction in flight at a time; data has priority, bounded by a streak limit.
module mem_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_kill,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_wstrb,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;          // 1 = data port owns the transaction
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            kill_pend_q, kill_pend_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            if_gnt_c, d_gnt_c;
    logic            win_d, win_if;

    // Fetch only overtakes a waiting data request once the streak limit is reached.
    assign win_d  = d_req && !(if_req && (streak_q == STREAK_MAX));
    assign win_if = if_req && !win_d;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        streak_d    = streak_q;
        kill_pend_d = kill_pend_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_gnt_c    = 1'b0;
        d_gnt_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_d) begin
                    d_gnt_c  = 1'b1;
                    owner_d  = 1'b1;
                    we_d     = d_we;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    wstrb_d  = d_we ? d_wstrb : 4'b0000;
                    // A grant while fetch waits implies streak < limit, so no overflow.
                    streak_d = if_req ? streak_q + SW'(1) : '0;
                    state_d  = REQ;
                end else if (win_if) begin
                    if_gnt_c    = 1'b1;
                    owner_d     = 1'b0;
                    we_d        = 1'b0;
                    addr_d      = if_addr;
                    wdata_d     = '0;
                    wstrb_d     = 4'b0000;
                    streak_d    = '0;
                    kill_pend_d = if_kill;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (!owner_q && if_kill) kill_pend_d = 1'b1;
                if (mem_gnt) state_d = RESP;
            end
            RESP: begin
                if (!owner_q && if_kill) kill_pend_d = 1'b1;
                if (mem_rvalid) begin
                    state_d     = IDLE;
                    kill_pend_d = 1'b0;
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_rdata;
                    end else if (!(kill_pend_q || if_kill)) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= 4'b0000;
            streak_q    <= '0;
            kill_pend_q <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            streak_q    <= streak_d;
            kill_pend_q <= kill_pend_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Grants are combinational, so hold them low while reset is asserted.
    assign if_gnt    = if_gnt_c & ~rst;
    assign d_gnt     = d_gnt_c & ~rst;
    assign if_rvalid = if_rvalid_q & ~if_kill;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

endmodule
